// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : 8N1 UART receiver with a first-word fall-through byte FIFO.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DIV   = 868,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     urx,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int c_CW   = $clog2(DIV);
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CNTW = c_AW + 1;

    localparam logic [c_CW-1:0]   c_BIT_END  = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0]   c_HALF_END = c_CW'(DIV / 2 - 1);
    localparam logic [c_CW-1:0]   c_CNT_INC  = c_CW'(1);
    localparam logic [c_AW-1:0]   c_PTR_INC  = c_AW'(1);
    localparam logic [c_CNTW-1:0] c_OCC_ONE  = c_CNTW'(1);
    localparam logic [c_CNTW-1:0] c_OCC_FULL = c_CNTW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sync1, r_rxs, r_prev;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_push, w_ferr_set;

    logic [7:0]        r_mem [DEPTH];
    logic [c_AW-1:0]   r_wptr, r_rptr;
    logic [c_CNTW-1:0] r_count;
    logic [7:0]        r_head, w_head_nxt;
    logic              r_ferr, r_ovr;
    logic              w_empty, w_full, w_pop, w_wr, w_ovr_set;

    // Synchronizer and previous-sample flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= urx;
            r_rxs   <= r_sync1;
            r_prev  <= r_rxs;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_INC;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_prev && !r_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF_END) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_BIT_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_push      = r_rxs;
                    w_ferr_set  = !r_rxs;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_OCC_FULL);
    assign w_pop     = rd_en && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // Head register holds the last head byte once the FIFO drains.
    always_comb begin
        w_head_nxt = r_head;
        if (w_wr && (w_empty || (w_pop && r_count == c_OCC_ONE)))
            w_head_nxt = r_shift;
        else if (w_pop && r_count > c_OCC_ONE)
            w_head_nxt = r_mem[r_rptr + c_PTR_INC];
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_head <= w_head_nxt;
            if (w_wr)  r_wptr <= r_wptr + c_PTR_INC;
            if (w_pop) r_rptr <= r_rptr + c_PTR_INC;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
            r_ferr <= w_ferr_set | (r_ferr & ~clr_err);
            r_ovr  <= w_ovr_set  | (r_ovr  & ~clr_err);
        end
    end

    assign rd_data    = r_head;
    assign rx_valid   = !w_empty;
    assign fifo_count = r_count;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire
